l2data_banked: RTL and testbench

Parametrised L2 data store: a banked data array with one request port (word read, critical-word-first line read, masked word write) and one snoop-readout port, each returning data through its own credit-controlled output FIFO. It sits between the L2 tag pipeline (ports `req_*`, `snp_*`) and its consumers: the L2 response path (`resp_*`) and the bus transaction unit (`sout_*`). Compared with the fixed 4-way/512-set store, geometry is generic. Backpressure never stalls the bank pipeline; it only blocks issue. Snoop/request arbitration is fair at line granularity.

---
 rtl/l2data_banked.sv | 262 ++++++++++++++++++++++++++
 tb/tb_l2data_banked.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2data_banked.sv
// Banked L2 data array: one request port and one snoop-readout port, each draining
// through its own credit-controlled first-word-fall-through output FIFO.
module l2data_banked #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 512,
  parameter int unsigned BEATS  = 8,
  parameter int unsigned BANKS  = 4,
  parameter int unsigned FDEPTH = 2,
  parameter int unsigned TAGW   = 5,
  localparam int unsigned BW    = $clog2(BEATS),
  localparam int unsigned SW    = $clog2(SETS),
  localparam int unsigned LA    = 3 + BW,
  localparam int unsigned AH    = LA + SW - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [AH-3:0]   req_addr,
  input  logic [WAYS-1:0] req_way,
  input  logic [7:0]      req_wmask,
  input  logic [63:0]     req_wdata,
  output logic            req_ready,
  input  logic            snp_valid,
  input  logic [TAGW-1:0] snp_tag,
  input  logic [AH-LA:0]  snp_addr,
  input  logic [WAYS-1:0] snp_way,
  output logic            snp_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [63:0]     resp_data,
  output logic [BW-1:0]   resp_beat,
  output logic            resp_last,
  output logic            sout_valid,
  input  logic            sout_ready,
  output logic [TAGW-1:0] sout_tag,
  output logic [63:0]     sout_data,
  output logic            sout_last,
  output logic            idle
);

  localparam int unsigned BKW  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int unsigned WIW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BPB  = BEATS / BANKS;
  localparam int unsigned ROWS = WAYS * SETS * BPB;
  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned PW   = $clog2(FDEPTH);
  localparam int unsigned CW   = $clog2(FDEPTH + 1);
  localparam int unsigned RFW  = BW + 1 + 64;
  localparam int unsigned SFW  = TAGW + 1 + 64;
  localparam logic [1:0]  OpRdl = 2'd1;

  function automatic logic [WIW-1:0] way_idx(input logic [WAYS-1:0] oh);
    way_idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (oh[i]) way_idx = WIW'(i);
    end
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == FDEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Request holding register
  logic            r_rv;
  logic [1:0]      r_rop;
  logic [SW-1:0]   r_rset;
  logic [BW-1:0]   r_rbeat;
  logic [BW-1:0]   r_rcnt;
  logic [WAYS-1:0] r_rway;
  logic [7:0]      r_rwmask;
  logic [63:0]     r_rwdata;

  // Snoop holding register
  logic            r_sv;
  logic [TAGW-1:0] r_stag;
  logic [SW-1:0]   r_sset;
  logic [BW-1:0]   r_sbeat;
  logic [WAYS-1:0] r_sway;

  logic            r_rprio;

  // Bank read stage
  logic            r_rd_v;
  logic            r_rd_snp;
  logic [BW-1:0]   r_rd_beat;
  logic            r_rd_last;
  logic [TAGW-1:0] r_rd_tag;
  logic [63:0]     r_rd_data;

  logic [63:0]     r_mem [BANKS][ROWS];

  // Output FIFOs
  logic [RFW-1:0]  r_rf_mem [FDEPTH];
  logic [PW-1:0]   r_rf_wp, r_rf_rp;
  logic [CW-1:0]   r_rf_cnt;
  logic [SFW-1:0]  r_sf_mem [FDEPTH];
  logic [PW-1:0]   r_sf_wp, r_sf_rp;
  logic [CW-1:0]   r_sf_cnt;

  logic            w_r_is_wr, w_r_is_rdl;
  logic            w_rf_push, w_rf_pop, w_sf_push, w_sf_pop;
  logic [CW-1:0]   w_rf_next, w_sf_next;
  logic            w_resp_cred, w_sout_cred;
  logic            w_pick_s, w_r_iss, w_s_iss, w_r_fin, w_s_fin;
  logic            w_rd_en, w_wr_en;
  logic [BW-1:0]   w_beat;
  logic [SW-1:0]   w_set;
  logic [WIW-1:0]  w_widx;
  logic [BKW-1:0]  w_bank;
  logic [RW-1:0]   w_row;

  assign w_r_is_wr  = r_rop[1];
  assign w_r_is_rdl = (r_rop == OpRdl);

  assign w_rf_push = r_rd_v & ~r_rd_snp;
  assign w_sf_push = r_rd_v & r_rd_snp;
  assign w_rf_pop  = resp_valid & resp_ready;
  assign w_sf_pop  = sout_valid & sout_ready;
  assign w_rf_next = r_rf_cnt + CW'(w_rf_push) - CW'(w_rf_pop);
  assign w_sf_next = r_sf_cnt + CW'(w_sf_push) - CW'(w_sf_pop);

  // Credit looks at next cycle's FIFO level: the in-flight beat lands and this
  // cycle's pop leaves, so a beat issued now always has a slot when it arrives.
  assign w_resp_cred = 32'(w_rf_next) < FDEPTH;
  assign w_sout_cred = 32'(w_sf_next) < FDEPTH;

  // The picked port issues only if it has credit; it never yields the slot.
  always_comb begin
    w_pick_s = r_sv & ~r_rprio;
    w_s_iss  = w_pick_s & w_sout_cred;
    w_r_iss  = ~w_pick_s & r_rv & (w_r_is_wr | w_resp_cred);
    w_r_fin  = w_r_iss & (~w_r_is_rdl | (r_rcnt == BW'(BEATS - 1)));
    w_s_fin  = w_s_iss & (r_sbeat == BW'(BEATS - 1));
    w_rd_en  = w_s_iss | (w_r_iss & ~w_r_is_wr);
    w_wr_en  = w_r_iss & w_r_is_wr & ~rst;
  end

  assign req_ready = ~r_rv | w_r_fin;
  assign snp_ready = ~r_sv | w_s_fin;

  always_comb begin
    w_beat = w_s_iss ? r_sbeat : r_rbeat;
    w_set  = w_s_iss ? r_sset : r_rset;
    w_widx = w_s_iss ? way_idx(r_sway) : way_idx(r_rway);
    w_bank = BKW'(32'(w_beat) % BANKS);
    w_row  = RW'((32'(w_widx) * SETS + 32'(w_set)) * BPB + 32'(w_beat) / BANKS);
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (r_rwmask[i]) r_mem[w_bank][w_row][8*i +: 8] <= r_rwdata[8*i +: 8];
      end
    end
    if (w_rd_en) r_rd_data <= r_mem[w_bank][w_row];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rv     <= 1'b0;
      r_rop    <= '0;
      r_rset   <= '0;
      r_rbeat  <= '0;
      r_rcnt   <= '0;
      r_rway   <= '0;
      r_rwmask <= '0;
      r_rwdata <= '0;
    end else if (req_valid & req_ready) begin
      r_rv     <= 1'b1;
      r_rop    <= req_op;
      r_rset   <= req_addr[BW +: SW];
      r_rbeat  <= req_addr[BW-1:0];
      r_rcnt   <= '0;
      r_rway   <= req_way;
      r_rwmask <= req_wmask;
      r_rwdata <= req_wdata;
    end else if (w_r_fin) begin
      r_rv <= 1'b0;
    end else if (w_r_iss) begin
      r_rbeat <= r_rbeat + 1'b1;
      r_rcnt  <= r_rcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sv    <= 1'b0;
      r_stag  <= '0;
      r_sset  <= '0;
      r_sbeat <= '0;
      r_sway  <= '0;
    end else if (snp_valid & snp_ready) begin
      r_sv    <= 1'b1;
      r_stag  <= snp_tag;
      r_sset  <= snp_addr[SW-1:0];
      r_sbeat <= '0;
      r_sway  <= snp_way;
    end else if (w_s_fin) begin
      r_sv <= 1'b0;
    end else if (w_s_iss) begin
      r_sbeat <= r_sbeat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rprio <= 1'b0;
    end else if (w_r_fin) begin
      r_rprio <= 1'b0;
    end else if (w_s_fin & r_rv) begin
      r_rprio <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_v    <= 1'b0;
      r_rd_snp  <= 1'b0;
      r_rd_beat <= '0;
      r_rd_last <= 1'b0;
      r_rd_tag  <= '0;
    end else begin
      r_rd_v    <= w_rd_en;
      r_rd_snp  <= w_s_iss;
      r_rd_beat <= r_rbeat;
      r_rd_last <= w_s_iss ? w_s_fin : w_r_fin;
      r_rd_tag  <= r_stag;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rf_push) r_rf_mem[r_rf_wp] <= {r_rd_beat, r_rd_last, r_rd_data};
    if (w_sf_push) r_sf_mem[r_sf_wp] <= {r_rd_tag, r_rd_last, r_rd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_wp  <= '0;
      r_rf_rp  <= '0;
      r_rf_cnt <= '0;
      r_sf_wp  <= '0;
      r_sf_rp  <= '0;
      r_sf_cnt <= '0;
    end else begin
      if (w_rf_push) r_rf_wp <= ptr_inc(r_rf_wp);
      if (w_rf_pop)  r_rf_rp <= ptr_inc(r_rf_rp);
      if (w_sf_push) r_sf_wp <= ptr_inc(r_sf_wp);
      if (w_sf_pop)  r_sf_rp <= ptr_inc(r_sf_rp);
      r_rf_cnt <= w_rf_next;
      r_sf_cnt <= w_sf_next;
    end
  end

  assign resp_valid = (r_rf_cnt != '0);
  assign sout_valid = (r_sf_cnt != '0);
  assign {resp_beat, resp_last, resp_data} = r_rf_mem[r_rf_rp];
  assign {sout_tag, sout_last, sout_data}  = r_sf_mem[r_sf_rp];

  assign idle = ~r_rv & ~r_sv & ~r_rd_v & (r_rf_cnt == '0) & (r_sf_cnt == '0);

endmodule

// File: tb/tb_l2data_banked.sv
// Directed bench for l2data_banked: write/read, critical-word-first bursts,
// backpressure, snoop interleave with fairness, byte masks and mid-burst reset.
module tb_l2data_banked;

  localparam int unsigned WAYS   = 4;
  localparam int unsigned SETS   = 512;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned BANKS  = 4;
  localparam int unsigned FDEPTH = 2;
  localparam int unsigned TAGW   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, snp_valid, snp_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [3:0]  req_way, snp_way;
  logic [7:0]  req_wmask;
  logic [63:0] req_wdata, resp_data, sout_data;
  logic [4:0]  snp_tag, sout_tag;
  logic [8:0]  snp_addr;
  logic        resp_valid, resp_ready, resp_last, sout_valid, sout_ready, sout_last, idle;
  logic [2:0]  resp_beat;

  l2data_banked #(
    .WAYS(WAYS), .SETS(SETS), .BEATS(BEATS), .BANKS(BANKS), .FDEPTH(FDEPTH), .TAGW(TAGW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_way(req_way),
    .req_wmask(req_wmask), .req_wdata(req_wdata), .req_ready(req_ready),
    .snp_valid(snp_valid), .snp_tag(snp_tag), .snp_addr(snp_addr), .snp_way(snp_way),
    .snp_ready(snp_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_beat(resp_beat), .resp_last(resp_last),
    .sout_valid(sout_valid), .sout_ready(sout_ready), .sout_tag(sout_tag),
    .sout_data(sout_data), .sout_last(sout_last), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_rlast, t_s1, t_s2, t_dummy;
  logic [63:0] model [int];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int key(input int w, input int s, input int b);
    return (w * SETS + s) * BEATS + b;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [1:0] op, input int set, input int beat,
                          input logic [3:0] way, input logic [7:0] m, input logic [63:0] d);
    bit ok = 1'b0;
    req_valid = 1'b1; req_op = op; req_addr = {9'(set), 3'(beat)};
    req_way = way; req_wmask = m; req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("req_accept", ok, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send_snp(input logic [4:0] tag, input int set, input logic [3:0] way);
    bit ok = 1'b0;
    snp_valid = 1'b1; snp_tag = tag; snp_addr = 9'(set); snp_way = way;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (snp_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("snp_accept", ok, 1);
    @(negedge clk);
    snp_valid = 1'b0;
  endtask

  // Masked write through the request port, mirrored into the model.
  task automatic wr(input logic [1:0] op, input int set, input int beat, input logic [3:0] way,
                    input int widx, input logic [7:0] m, input logic [63:0] d);
    logic [63:0] v;
    int k = key(widx, set, beat);
    v = model.exists(k) ? model[k] : 64'h0;
    for (int i = 0; i < 8; i++) if (m[i]) v[8*i +: 8] = d[8*i +: 8];
    model[k] = v;
    send_req(op, set, beat, way, m, d);
  endtask

  task automatic write_line(input int set, input int widx, input logic [63:0] base);
    for (int b = 0; b < BEATS; b++) wr(2'd2, set, b, 4'(1 << widx), widx, 8'hFF, base + 64'(b));
  endtask

  task automatic collect_resp(input int n, input int widx, input int set, input int beat0,
                              output int t_last);
    int got = 0;
    t_last = 0;
    for (int c = 0; c < 150 && got < n; c++) begin
      if (resp_valid && resp_ready) begin
        int b = (beat0 + got) % BEATS;
        check_eq("resp_beat", {resp_beat, resp_last, resp_data},
                 {3'(b), got == n - 1, model[key(widx, set, b)]});
        got++;
        t_last = cyc;
      end
      @(negedge clk);
    end
    check_eq("resp_count", got, n);
  endtask

  task automatic collect_sout(input logic [4:0] tag, input int widx, input int set,
                              output int t_first);
    int got = 0;
    t_first = 0;
    for (int c = 0; c < 150 && got < BEATS; c++) begin
      if (sout_valid && sout_ready) begin
        check_eq("sout_beat", {sout_tag, sout_last, sout_data},
                 {tag, got == BEATS - 1, model[key(widx, set, got)]});
        if (got == 0) t_first = cyc;
        got++;
      end
      @(negedge clk);
    end
    check_eq("sout_count", got, BEATS);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_valid = 0; req_op = 0; req_addr = 0; req_way = 0; req_wmask = 0; req_wdata = 0;
    snp_valid = 0; snp_tag = 0; snp_addr = 0; snp_way = 0;
    resp_ready = 1; sout_ready = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_snp_ready", snp_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_sout_valid", sout_valid, 0);
    check_eq("rst_idle", idle, 1);

    // Write then word read: data visible exactly two cycles after issue
    wr(2'd2, 1, 0, 4'b0100, 2, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5);
    send_req(2'd0, 1, 0, 4'b0100, 8'h00, 64'h0);
    @(negedge clk);
    check_eq("rdw_t1_empty", resp_valid, 0);
    @(negedge clk);
    check_eq("rdw_t2", {resp_valid, resp_beat, resp_last, resp_data},
             {1'b1, 3'd0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5});
    @(negedge clk);

    // Critical-word-first line read from beat 5
    write_line(3, 1, 64'hD00D_0000_0000_0000);
    write_line(7, 0, 64'hB0B0_0000_0000_0000);
    send_req(2'd1, 3, 5, 4'b0010, 8'h00, 64'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i < 8) check_eq("rdl_req_ready", req_ready, i == 7);
      if (i >= 2) check_eq("rdl_stream", {resp_valid, resp_beat, resp_last, resp_data},
                           {1'b1, 3'((5 + i - 2) % 8), i == 9,
                            model[key(1, 3, (5 + i - 2) % 8)]});
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("rdl_idle", idle, 1);

    // Backpressure: issue stops with the FIFO full, then drains in order
    resp_ready = 0;
    send_req(2'd1, 3, 0, 4'b0010, 8'h00, 64'h0);
    repeat (10) @(negedge clk);
    #1;
    check_eq("bp_head", {resp_valid, resp_beat, resp_data}, {1'b1, 3'd0, 64'hD00D_0000_0000_0000});
    check_eq("bp_req_held", req_ready, 0);
    check_eq("bp_not_idle", idle, 0);
    resp_ready = 1;
    collect_resp(8, 1, 3, 0, t_dummy);

    // Snoop preempts a line read; a second snoop waits until the read completes
    fork
      begin
        send_req(2'd1, 3, 2, 4'b0010, 8'h00, 64'h0);
        collect_resp(8, 1, 3, 2, t_rlast);
      end
      begin
        repeat (2) @(negedge clk);
        send_snp(5'h13, 7, 4'b0001);
        send_snp(5'h05, 3, 4'b0010);
      end
      begin
        collect_sout(5'h13, 0, 7, t_s1);
        collect_sout(5'h05, 1, 3, t_s2);
      end
    join
    check_eq("snoop_interleaves", t_s1 < t_rlast, 1);
    check_eq("rprio_order", t_s2 > t_rlast, 1);

    // Byte-masked write over all-ones
    wr(2'd2, 10, 3, 4'b1000, 3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(2'd2, 10, 3, 4'b1000, 3, 8'h0F, 64'h1234_5678_9ABC_DEF0);
    send_req(2'd0, 10, 3, 4'b1000, 8'h00, 64'h0);
    repeat (2) @(negedge clk);
    check_eq("mask_rdw", {resp_valid, resp_beat, resp_last, resp_data},
             {1'b1, 3'd3, 1'b1, 64'hFFFF_FFFF_9ABC_DEF0});
    @(negedge clk);

    // Reserved op writes; zero way vector reads way 0
    wr(2'd3, 12, 1, 4'b0001, 0, 8'hFF, 64'hCAFE_F00D_1234_0001);
    send_req(2'd0, 12, 1, 4'b0000, 8'h00, 64'h0);
    repeat (2) @(negedge clk);
    check_eq("op3_zero_way", {resp_valid, resp_beat, resp_last, resp_data},
             {1'b1, 3'd1, 1'b1, 64'hCAFE_F00D_1234_0001});
    @(negedge clk);

    // Reset in the middle of a line read
    send_req(2'd1, 3, 0, 4'b0010, 8'h00, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    check_eq("mid_rst_resp_valid", resp_valid, 0);
    check_eq("mid_rst_idle", idle, 1);
    check_eq("mid_rst_req_ready", req_ready, 1);
    check_eq("mid_rst_snp_ready", snp_ready, 1);
    rst = 0;
    @(negedge clk);
    send_req(2'd1, 3, 6, 4'b0010, 8'h00, 64'h0);
    collect_resp(8, 1, 3, 6, t_dummy);
    repeat (3) @(negedge clk);
    check_eq("final_idle", idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
